// File: rtl/dvs_ravens_pkg.sv
// rtl/dvs_ravens_pkg.sv - shared widths, decoded-event struct and timestamp FSM states
package dvs_ravens_pkg;

  localparam int DVS_X_ADDR_BITS    = 8;
  localparam int DVS_Y_ADDR_BITS    = 8;
  localparam int TIMESTAMP_US_BITS  = 16;
  localparam int EVENT_BITS         = DVS_X_ADDR_BITS + DVS_Y_ADDR_BITS + 1 + TIMESTAMP_US_BITS;
  // Widest neuron id any crop inside the sensor address space can produce.
  localparam int NEURON_ID_MAX_BITS = DVS_X_ADDR_BITS + DVS_Y_ADDR_BITS;

  typedef enum logic {
    TS_FIRST = 1'b0,
    TS_TRACK = 1'b1
  } ts_state_e;

  typedef struct packed {
    logic [NEURON_ID_MAX_BITS-1:0] neuron_id;
    logic                          polarity;
    logic [TIMESTAMP_US_BITS-1:0]  delta_us;
  } decoded_event_t;

endpackage

// File: rtl/dvs_event_fifo.sv
// rtl/dvs_event_fifo.sv - power-of-two synchronous FIFO, full/empty from wrap-bit pointers
module dvs_event_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, rd_ptr_q;
  logic             push_ok, pop_ok;

  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // Storage needs no reset: the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/dvs_event_decoder.sv
// rtl/dvs_event_decoder.sv - buffers DVS events, crops, maps to neuron id and timestamp delta
module dvs_event_decoder
  import dvs_ravens_pkg::*;
#(
  parameter int CROP_WIDTH  = 100,
  parameter int CROP_HEIGHT = 100,
  parameter int FIFO_DEPTH  = 4,
  localparam int NEURON_ID_BITS = $clog2(CROP_WIDTH * CROP_HEIGHT)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [EVENT_BITS-1:0]        in_event,
  input  logic                         in_valid,
  output logic                         in_ready,
  output logic [NEURON_ID_BITS-1:0]    out_neuron_id,
  output logic                         out_polarity,
  output logic [TIMESTAMP_US_BITS-1:0] out_delta_us,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [15:0]                  drop_count
);

  logic                         fifo_full, fifo_empty, fifo_pop;
  logic [EVENT_BITS-1:0]        head;
  logic [DVS_X_ADDR_BITS-1:0]   head_x;
  logic [DVS_Y_ADDR_BITS-1:0]   head_y;
  logic                         head_pol;
  logic [TIMESTAMP_US_BITS-1:0] head_ts;
  logic                         in_range, advance, load, drop;

  decoded_event_t               dec_d, dec_q;
  logic                         out_valid_q;
  logic [TIMESTAMP_US_BITS-1:0] last_ts_q;
  logic [15:0]                  drop_count_q;
  ts_state_e                    state_q;

  assign in_ready = !fifo_full && !rst;

  dvs_event_fifo #(
    .WIDTH (EVENT_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (in_valid && in_ready),
    .wdata_i (in_event),
    .pop_i   (fifo_pop),
    .rdata_o (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign head_x   = head[EVENT_BITS-1 -: DVS_X_ADDR_BITS];
  assign head_y   = head[EVENT_BITS-DVS_X_ADDR_BITS-1 -: DVS_Y_ADDR_BITS];
  assign head_pol = head[TIMESTAMP_US_BITS];
  assign head_ts  = head[TIMESTAMP_US_BITS-1:0];

  assign in_range = (int'(head_x) < CROP_WIDTH) && (int'(head_y) < CROP_HEIGHT);
  assign advance  = !out_valid_q || out_ready;
  assign fifo_pop = !fifo_empty && advance;
  assign load     = fifo_pop && in_range;
  assign drop     = fifo_pop && !in_range;

  // Subtraction at timestamp width makes counter wrap yield the true small delta.
  always_comb begin
    dec_d           = '0;
    dec_d.neuron_id = NEURON_ID_MAX_BITS'(int'(head_y) * CROP_WIDTH + int'(head_x));
    dec_d.polarity  = head_pol;
    dec_d.delta_us  = (state_q == TS_FIRST) ? '0 : (head_ts - last_ts_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dec_q        <= '0;
      out_valid_q  <= 1'b0;
      last_ts_q    <= '0;
      drop_count_q <= '0;
      state_q      <= TS_FIRST;
    end else begin
      if (load) begin
        dec_q       <= dec_d;
        out_valid_q <= 1'b1;
        last_ts_q   <= head_ts;
        state_q     <= TS_TRACK;
      end else if (out_ready) begin
        out_valid_q <= 1'b0;
      end
      if (drop && (drop_count_q != 16'hFFFF)) drop_count_q <= drop_count_q + 16'd1;
    end
  end

  assign out_neuron_id = NEURON_ID_BITS'(dec_q.neuron_id);
  assign out_polarity  = dec_q.polarity;
  assign out_delta_us  = dec_q.delta_us;
  assign out_valid     = out_valid_q;
  assign drop_count    = drop_count_q;

endmodule

// File: tb/tb_dvs_event_decoder.sv
// tb/tb_dvs_event_decoder.sv - directed and random checks of dvs_event_decoder against a queue model
module tb_dvs_event_decoder;
  import dvs_ravens_pkg::*;

  localparam int CW = 100;
  localparam int CH = 100;
  localparam int FD = 4;
  localparam int NB = $clog2(CW * CH);
  localparam int TS_MOD = 1 << TIMESTAMP_US_BITS;

  logic                         clk = 1'b0;
  logic                         rst;
  logic [EVENT_BITS-1:0]        in_event;
  logic                         in_valid;
  logic                         in_ready;
  logic [NB-1:0]                out_neuron_id;
  logic                         out_polarity;
  logic [TIMESTAMP_US_BITS-1:0] out_delta_us;
  logic                         out_valid;
  logic                         out_ready;
  logic [15:0]                  drop_count;

  dvs_event_decoder #(
    .CROP_WIDTH  (CW),
    .CROP_HEIGHT (CH),
    .FIFO_DEPTH  (FD)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .in_event      (in_event),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .out_neuron_id (out_neuron_id),
    .out_polarity  (out_polarity),
    .out_delta_us  (out_delta_us),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .drop_count    (drop_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int nid;
    bit pol;
    int delta;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  bit   m_first = 1'b1;
  int   m_last = 0;
  int   m_drop = 0;
  int   n_out = 0;
  int   n_acc = 0;
  int   last_nid = -1;
  int   last_delta = -1;
  int   cx, cy, cts;
  bit   cp;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // Reference model: what must come out, derived from each accepted event's fields.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      m_first = 1'b1;
      m_last  = 0;
      m_drop  = 0;
    end else begin
      if (out_valid && out_ready) begin
        n_out++;
        last_nid   = int'(out_neuron_id);
        last_delta = int'(out_delta_us);
        if (exp_q.size() == 0) begin
          chk("unexpected_output", 64'(exp_q.size()), 64'd1);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("neuron_id", 64'(out_neuron_id), 64'(e.nid));
          chk("polarity", 64'(out_polarity), 64'(e.pol));
          chk("delta_us", 64'(out_delta_us), 64'(e.delta));
        end
      end
      if (in_valid && in_ready) begin
        n_acc++;
        if (cx < CW && cy < CH) begin
          exp_t e;
          e.nid   = cy * CW + cx;
          e.pol   = cp;
          e.delta = m_first ? 0 : (cts - m_last + TS_MOD) % TS_MOD;
          exp_q.push_back(e);
          m_first = 1'b0;
          m_last  = cts;
        end else if (m_drop < 65535) begin
          m_drop++;
        end
      end
    end
  end

  task automatic drive(input int x, input int y, input bit p, input int ts);
    cx = x; cy = y; cp = p; cts = ts;
    in_event = {DVS_X_ADDR_BITS'(x), DVS_Y_ADDR_BITS'(y), p, TIMESTAMP_US_BITS'(ts)};
    in_valid = 1'b1;
  endtask

  task automatic wait_accept(output int waited);
    waited = 0;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      waited++;
      if (waited > 60) begin
        chk("accept_timeout", 64'(waited), 64'd0);
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic push_ev(input int x, input int y, input bit p, input int ts, output int waited);
    drive(x, y, p, ts);
    wait_accept(waited);
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int k;
    k = 0;
    while ((exp_q.size() != 0 || out_valid) && k < 300) begin
      @(posedge clk);
      #1;
      k++;
    end
    chk("drain_pending", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int w, wsum, o0, a0, d0;
    bit acc;
    logic [NB-1:0]                snap_nid;
    logic                         snap_pol;
    logic [TIMESTAMP_US_BITS-1:0] snap_dt;

    rst = 1'b1; in_valid = 1'b0; in_event = '0; out_ready = 1'b1;
    cx = 0; cy = 0; cp = 1'b0; cts = 0;
    cycles(2);
    @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_neuron_id", 64'(out_neuron_id), 64'd0);
    chk("rst_polarity", 64'(out_polarity), 64'd0);
    chk("rst_delta", 64'(out_delta_us), 64'd0);
    chk("rst_drop", 64'(drop_count), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("in_ready_after_rst", 64'(in_ready), 64'd1);

    // Single event latency: accepted at edge N, visible after N+1.
    @(posedge clk); #1;
    drive(5, 2, 1'b1, 1000);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("lat_not_yet", 64'(out_valid), 64'd0);
    @(posedge clk); #1;
    chk("lat_valid", 64'(out_valid), 64'd1);
    chk("lat_nid", 64'(out_neuron_id), 64'd205);
    chk("lat_pol", 64'(out_polarity), 64'd1);
    chk("lat_delta", 64'(out_delta_us), 64'd0);
    drain();

    push_ev(0, 0, 1'b0, 1000, w);
    push_ev(0, 0, 1'b1, 1250, w);
    in_valid = 1'b0;
    drain();
    chk("delta_250", 64'(last_delta), 64'd250);
    chk("nid_zero", 64'(last_nid), 64'd0);

    push_ev(3, 4, 1'b0, TS_MOD - 10, w);
    push_ev(3, 4, 1'b1, 5, w);
    in_valid = 1'b0;
    drain();
    chk("wrap_delta", 64'(last_delta), 64'd15);
    chk("wrap_nid", 64'(last_nid), 64'd403);

    // Sustained one-per-cycle with corner ids.
    o0 = n_out; wsum = 0;
    for (int k = 0; k < 8; k++) begin
      push_ev((k % 2) ? 99 : k, (k % 2) ? 99 : k, k[0], 3000 + 7 * k, w);
      wsum += w;
    end
    in_valid = 1'b0;
    drain();
    chk("tput_stalls", 64'(wsum), 64'd0);
    chk("tput_count", 64'(n_out - o0), 64'd8);

    // Backpressure: FIFO_DEPTH+1 accepted, then held.
    out_ready = 1'b0; a0 = n_acc; o0 = n_out; wsum = 0;
    for (int k = 0; k < FD + 1; k++) begin
      push_ev(k + 10, k, k[0], 4000 + 10 * k, w);
      wsum += w;
    end
    drive(20, 20, 1'b1, 4100);
    @(negedge clk);
    chk("bp_accepted", 64'(n_acc - a0), 64'(FD + 1));
    chk("bp_stalls", 64'(wsum), 64'd0);
    snap_nid = out_neuron_id; snap_pol = out_polarity; snap_dt = out_delta_us;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("bp_in_ready", 64'(in_ready), 64'd0);
      chk("bp_valid_hold", 64'(out_valid), 64'd1);
      chk("bp_nid_hold", 64'(out_neuron_id), 64'(snap_nid));
      chk("bp_pol_hold", 64'(out_polarity), 64'(snap_pol));
      chk("bp_delta_hold", 64'(out_delta_us), 64'(snap_dt));
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    wait_accept(w);
    in_valid = 1'b0;
    drain();
    chk("bp_all_out", 64'(n_out - o0), 64'(FD + 2));
    chk("bp_sixth_in", 64'(n_acc - a0), 64'(FD + 2));

    // Out-of-crop drop between two in-range events.
    rst = 1'b1;
    cycles(1);
    rst = 1'b0;
    o0 = n_out;
    push_ev(1, 1, 1'b0, 100, w);
    push_ev(100, 0, 1'b1, 200, w);
    push_ev(2, 1, 1'b1, 300, w);
    in_valid = 1'b0;
    drain();
    chk("drop_count", 64'(drop_count), 64'd1);
    chk("drop_outputs", 64'(n_out - o0), 64'd2);
    chk("drop_delta", 64'(last_delta), 64'd200);
    chk("drop_nid", 64'(last_nid), 64'd102);

    // Reset with a presented output and buffered events.
    out_ready = 1'b0;
    for (int k = 0; k < 4; k++) push_ev(k, 9, 1'b0, 500 + k, w);
    in_valid = 1'b0;
    @(negedge clk);
    chk("pre_rst_valid", 64'(out_valid), 64'd1);
    chk("pre_rst_drop", 64'(drop_count), 64'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("post_rst_valid", 64'(out_valid), 64'd0);
    chk("post_rst_drop", 64'(drop_count), 64'd0);
    o0 = n_out;
    cycles(10);
    chk("post_rst_silent", 64'(n_out - o0), 64'd0);
    push_ev(7, 7, 1'b0, 777, w);
    in_valid = 1'b0;
    drain();
    chk("post_rst_first_delta", 64'(last_delta), 64'd0);
    chk("post_rst_first_nid", 64'(last_nid), 64'd707);

    // Random traffic with random backpressure; the model checks each output.
    d0 = n_out;
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      acc = in_valid && in_ready;
      @(posedge clk); #1;
      if (!in_valid || acc) begin
        if ($urandom_range(0, 3) != 0)
          drive(int'($urandom_range(0, 119)), int'($urandom_range(0, 119)),
                bit'($urandom_range(0, 1)), int'($urandom_range(0, TS_MOD - 1)));
        else
          in_valid = 1'b0;
      end
      out_ready = ($urandom_range(0, 4) != 0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    drain();
    chk("rand_drop_count", 64'(drop_count), 64'(m_drop));
    chk("rand_progress", 64'(n_out - d0 > 100), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
